datapath_scheduler: RTL
=======================

Name: datapath_scheduler

Overview:
- Sole owner of the Datapath start/instruction/finished handshake.
- Shares the datapath between two requesters:
  - a command port used by game/neuroevolution logic, with valid/ready handshake and a result return;
  - an internal frame-refresh scanner that issues one DISPLAY instruction per pixel.
- Arbitration is command-priority with a starvation guard, so the screen keeps refreshing under heavy command traffic.

Parameters:
- INSTR_W, 32, datapath instruction width.
- RESULT_W, 12, datapath result width.
- OPCODE_W, 4, opcode field width (instruction bits [OPCODE_W-1:0]).
- OPCODE_DISPLAY, 4'd3, opcode used for scanner-issued pixel refresh.
- SCREEN_W, 160, pixels per row (x field width 8).
- SCREEN_H, 120, rows (y field width 7).
- MAX_CMD_BURST, 4, maximum consecutive command grants while a scan is active.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_instruction  in  INSTR_W  command instruction.
- rsp_valid  out  1  one-cycle pulse: command completed.
- rsp_result  out  RESULT_W  datapath result for that command; held until the next rsp_valid.
- refresh_req  in  1  pulse: request one full-frame scan.
- refresh_busy  out  1  scan active.
- frame_done  out  1  one-cycle pulse after the last pixel of a scan.
- dp_start  out  1  to datapath start.
- dp_instruction  out  INSTR_W  to datapath instruction.
- dp_finished  in  1  from datapath finished.
- dp_result  in  RESULT_W  from datapath result.

Behaviour:
- Reset values:
  - state IDLE;
  - dp_start, dp_instruction, rsp_valid, rsp_result, frame_done, refresh_busy all 0;
  - scan x/y, pending flag and burst_cnt all 0.
- Reset mid-operation abandons any in-flight grant and scan; no rsp_valid or frame_done is produced. Top level drives datapath resetn = ~reset.
- FSM states:
  - IDLE to ISSUE when dp_finished=1 and a grant is made.
  - ISSUE (dp_start=1 for exactly this cycle) to BUSY unconditionally.
  - BUSY to IDLE on the edge where dp_finished=1 is sampled.
- Grant rules, evaluated in IDLE with dp_finished=1:
  - scan_turn = refresh_busy && (!cmd_valid || burst_cnt==MAX_CMD_BURST).
  - cmd_ready is combinational: (state==IDLE) && dp_finished && !scan_turn.
  - Otherwise, if refresh_busy, the scanner is granted.
  - cmd_ready=0 in ISSUE and BUSY.
- Command grant:
  - dp_instruction <= cmd_instruction; owner<=CMD.
  - burst_cnt increments, saturating at MAX_CMD_BURST, only while refresh_busy.
- Scan grant:
  - dp_instruction <= {zeros, y[6:0] at [18:12], x[7:0] at [11:4], OPCODE_DISPLAY at [3:0]}.
  - owner<=SCAN; burst_cnt<=0.
- Completion in BUSY with dp_finished=1:
  - CMD owner: rsp_valid=1 next cycle, rsp_result=dp_result.
  - SCAN owner: x increments.
    - At x=SCREEN_W-1: x<=0 and y increments.
    - At (SCREEN_W-1, SCREEN_H-1): frame_done pulses next cycle and the scan ends (refresh_busy<=0), unless a refresh is pending, in which case the scan restarts at (0,0), pending clears and refresh_busy stays 1.
- Command latency: at least 2 cycles from the accept edge to dp_finished returning, plus 1 cycle to rsp_valid.
- refresh_req handling:
  - While idle: refresh_busy<=1 next cycle, scan starts at (0,0).
  - While busy: sets pending, one deep; further requests merge.
  - refresh_req coinciding with the last-pixel completion counts as pending, so the scan restarts.
- refresh_busy deasserted means burst_cnt is held at 0.

Optional Feature:
- Macro: DATAPATH_SCHED_STATS_EN.
- Defined adds output frame_count (16 bits), incrementing with wrap on each frame_done.
- Also adds output stall_count (16 bits), incrementing each cycle cmd_valid=1 && cmd_ready=0, saturating at 16'hFFFF.
- Both counters reset to 0.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Shared constants header, alongside the existing one:
  - opcode encodings (OPCODE_DISPLAY etc.);
  - instruction field positions (X [11:4], Y [18:12], opcode [3:0]);
  - SCREEN_W / SCREEN_H;
  - INSTR_W / RESULT_W.
- Sub-module pixel_scan_counter:
  - x/y counters with advance, restart, last_pixel outputs;
  - the scheduler FSM and arbiter stay in the top module.

Test Plan:
- Bench uses a datapath model whose finished drops the edge after start and rises after N=2 cycles.
- Single command: cmd_valid=1, instruction 32'h0000_1232 (MEMREAD, addr 0x123), model result 12'hABC -> cmd_ready for 1 cycle, exactly one dp_start, rsp_valid one cycle with rsp_result=12'hABC.
- Full scan, no commands: refresh_req pulse -> 19200 dp_starts.
  - First dp_instruction = 32'h0000_0003, last = 32'h0007_79F3 (x=159, y=119).
  - One frame_done, then refresh_busy=0.
- Starvation guard: scan active, cmd_valid held 1 -> grant pattern of 4 CMD, 1 SCAN, repeating; no command lost; the scan still completes.
- Pending refresh: refresh_req pulsed twice mid-scan -> exactly two frames.
  - Second starts at (0,0) with no IDLE gap in refresh_busy.
  - Two frame_done pulses.
- Reset mid-BUSY (command in flight) -> all outputs 0 next cycle, no rsp_valid, no further dp_start until new requests arrive.
- Stats build (DATAPATH_SCHED_STATS_EN defined): after 2 frames and 7 stalled cycles -> frame_count=2, stall_count=7.

Source files
------------

// File: rtl/datapath_scheduler_pkg.sv
// Shared constants for the datapath scheduler: instruction layout, opcodes, screen geometry.
// The optional DATAPATH_SCHED_STATS_EN build adds the frame/stall counter width used here.
package datapath_scheduler_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned RESULT_W      = 12;
  localparam int unsigned OPCODE_W      = 4;
  localparam int unsigned X_W           = 8;
  localparam int unsigned Y_W           = 7;
  localparam int unsigned X_LSB         = OPCODE_W;
  localparam int unsigned Y_LSB         = X_LSB + X_W;
  localparam int unsigned SCREEN_W      = 160;
  localparam int unsigned SCREEN_H      = 120;
  localparam int unsigned MAX_CMD_BURST = 4;
  localparam int unsigned BURST_W       = $clog2(MAX_CMD_BURST + 1);
  localparam int unsigned STATS_W       = 16;

  localparam logic [OPCODE_W-1:0] OPCODE_MEMREAD = 4'd2;
  localparam logic [OPCODE_W-1:0] OPCODE_DISPLAY = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CMD  = 1'b0,
    OWN_SCAN = 1'b1
  } owner_e;

  // Pixel refresh instruction: y at [18:12], x at [11:4], opcode at [3:0].
  typedef struct packed {
    logic [INSTR_W-Y_LSB-Y_W-1:0] rsvd;
    logic [Y_W-1:0]               y;
    logic [X_W-1:0]               x;
    logic [OPCODE_W-1:0]          opcode;
  } display_instr_t;

  function automatic logic [INSTR_W-1:0] display_instr(input logic [X_W-1:0] x,
                                                       input logic [Y_W-1:0] y);
    display_instr_t d;
    d.rsvd   = '0;
    d.y      = y;
    d.x      = x;
    d.opcode = OPCODE_DISPLAY;
    return d;
  endfunction

endpackage

// File: rtl/datapath_scheduler_pixel_scan_counter.sv
// Raster x/y position of the frame-refresh scanner; wraps to (0,0) after the last pixel.
module pixel_scan_counter
  import datapath_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH  = SCREEN_W,
  parameter int unsigned HEIGHT = SCREEN_H
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           advance,
  input  logic           restart,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_W'(WIDTH - 1)) begin
        x <= '0;
        y <= (y == Y_W'(HEIGHT - 1)) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign last_pixel = (x == X_W'(WIDTH - 1)) && (y == Y_W'(HEIGHT - 1));

endmodule

// File: rtl/datapath_scheduler.sv
// Arbitrates the datapath between the command port and the frame-refresh scanner.
// Defining DATAPATH_SCHED_STATS_EN adds frame_count and stall_count outputs.
module datapath_scheduler #(
  parameter int unsigned SCREEN_W = datapath_scheduler_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = datapath_scheduler_pkg::SCREEN_H
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        cmd_valid,
  output logic                                        cmd_ready,
  input  logic [datapath_scheduler_pkg::INSTR_W-1:0]  cmd_instruction,
  output logic                                        rsp_valid,
  output logic [datapath_scheduler_pkg::RESULT_W-1:0] rsp_result,
  input  logic                                        refresh_req,
  output logic                                        refresh_busy,
  output logic                                        frame_done,
  output logic                                        dp_start,
  output logic [datapath_scheduler_pkg::INSTR_W-1:0]  dp_instruction,
  input  logic                                        dp_finished,
  input  logic [datapath_scheduler_pkg::RESULT_W-1:0] dp_result
`ifdef DATAPATH_SCHED_STATS_EN
  ,
  output logic [datapath_scheduler_pkg::STATS_W-1:0]  frame_count,
  output logic [datapath_scheduler_pkg::STATS_W-1:0]  stall_count
`endif
);
  import datapath_scheduler_pkg::*;

  state_e               state, next_state;
  owner_e               owner;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 pending;
  logic [X_W-1:0]       scan_x;
  logic [Y_W-1:0]       scan_y;
  logic                 last_pixel;
  logic                 scan_turn, cmd_grant, scan_grant;
  logic                 cmd_done, scan_done, frame_end;

  pixel_scan_counter #(.WIDTH(SCREEN_W), .HEIGHT(SCREEN_H)) u_scan (
    .clock      (clock),
    .reset      (reset),
    .advance    (scan_done),
    .restart    (refresh_req && !refresh_busy),
    .x          (scan_x),
    .y          (scan_y),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (cmd_grant || scan_grant) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_BUSY;
      ST_BUSY:  if (dp_finished) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The scanner wins when commands are absent or have used up their burst allowance.
  always_comb begin
    scan_turn  = refresh_busy && (!cmd_valid || (burst_cnt == BURST_W'(MAX_CMD_BURST)));
    cmd_ready  = (state == ST_IDLE) && dp_finished && !scan_turn;
    cmd_grant  = cmd_ready && cmd_valid;
    scan_grant = (state == ST_IDLE) && dp_finished && scan_turn;
    cmd_done   = (state == ST_BUSY) && dp_finished && (owner == OWN_CMD);
    scan_done  = (state == ST_BUSY) && dp_finished && (owner == OWN_SCAN);
    frame_end  = scan_done && last_pixel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dp_start       <= 1'b0;
      dp_instruction <= '0;
      owner          <= OWN_CMD;
      burst_cnt      <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      frame_done     <= 1'b0;
      refresh_busy   <= 1'b0;
      pending        <= 1'b0;
    end else begin
      dp_start   <= cmd_grant || scan_grant;
      rsp_valid  <= cmd_done;
      frame_done <= frame_end;
      if (cmd_done) rsp_result <= dp_result;

      if (cmd_grant) begin
        dp_instruction <= cmd_instruction;
        owner          <= OWN_CMD;
      end else if (scan_grant) begin
        dp_instruction <= display_instr(scan_x, scan_y);
        owner          <= OWN_SCAN;
      end

      if (!refresh_busy || scan_grant) burst_cnt <= '0;
      else if (cmd_grant && (burst_cnt != BURST_W'(MAX_CMD_BURST))) burst_cnt <= burst_cnt + BURST_W'(1);

      // A request landing on the last pixel counts as pending, so the scan wraps straight on.
      if (frame_end) begin
        pending <= 1'b0;
        if (!(pending || refresh_req)) refresh_busy <= 1'b0;
      end else if (refresh_req) begin
        if (refresh_busy) pending      <= 1'b1;
        else              refresh_busy <= 1'b1;
      end
    end
  end

`ifdef DATAPATH_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (frame_end) frame_count <= frame_count + STATS_W'(1);
      if (cmd_valid && !cmd_ready && (stall_count != {STATS_W{1'b1}}))
        stall_count <= stall_count + STATS_W'(1);
    end
  end
`endif

endmodule
